// File: rtl/mips_pkg.sv
// Shared MIPS32 definitions: funct codes, multiply/divide FSM states and
// the sign-conditioning helper used on entry to and exit from the muldiv unit.
package mips_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;

   typedef enum logic [1:0] {
      MD_IDLE,
      MD_MUL,
      MD_DIV,
      MD_FIX
   } md_state_t;

   // Two's-complement negate when neg is set; doubles as abs() on entry
   // (neg = sign bit) and as sign application on exit.
   function automatic logic [2*XLEN-1:0] cond_neg(input logic [2*XLEN-1:0] v,
                                                  input logic              neg);
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MIPS32 multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply (LSB first) and restoring divide (MSB first) on
// magnitudes, one bit per cycle, followed by a single sign-fix cycle.
module muldiv_unit #(
   parameter int unsigned SIZE     = 32,
   parameter int unsigned SIZE_FNC = 6,
   parameter int unsigned CNT_W    = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [SIZE_FNC-1:0] funcion,
   input  logic [SIZE-1:0]     op_a,
   input  logic [SIZE-1:0]     op_b,
   output logic                busy,
   output logic                done,
   output logic [SIZE-1:0]     hi,
   output logic [SIZE-1:0]     lo,
   output logic [SIZE-1:0]     result
);
   import mips_pkg::*;

   md_state_t         state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [SIZE-1:0]   mag_a, mag_b;
   logic              sign_a, sign_b, op_div;
   logic [2*SIZE-1:0] acc;

   logic              is_mul, is_div, is_signed, neg_a_in, neg_b_in, last_iter;
   logic [2*SIZE-1:0] a_cond, b_cond, prod_fix, quo_fix, rem_fix, a_orig;
   logic [SIZE:0]     mul_sum, div_shift, div_diff;
   logic              div_ge;
   logic [2*SIZE-1:0] mul_next, div_next;
   logic              unused_hi_halves;

   assign busy   = (state != MD_IDLE);
   assign result = (funcion == FN_MFHI) ? hi : lo;

   // Decode, sign conditioning and one iteration step of each algorithm
   always_comb begin
      is_mul    = (funcion == FN_MULT) || (funcion == FN_MULTU);
      is_div    = (funcion == FN_DIV)  || (funcion == FN_DIVU);
      is_signed = (funcion == FN_MULT) || (funcion == FN_DIV);
      neg_a_in  = is_signed & op_a[SIZE-1];
      neg_b_in  = is_signed & op_b[SIZE-1];
      a_cond    = cond_neg({{SIZE{1'b0}}, op_a}, neg_a_in);
      b_cond    = cond_neg({{SIZE{1'b0}}, op_b}, neg_b_in);
      prod_fix  = cond_neg(acc, sign_a ^ sign_b);
      quo_fix   = cond_neg({{SIZE{1'b0}}, acc[2*SIZE-1:SIZE]}, sign_a ^ sign_b);
      rem_fix   = cond_neg({{SIZE{1'b0}}, acc[SIZE-1:0]}, sign_a);
      a_orig    = cond_neg({{SIZE{1'b0}}, mag_a}, sign_a);
      last_iter = (cnt == CNT_W'(SIZE - 1));

      // Multiply: acc holds the running product shifted right each step
      mul_sum   = {1'b0, acc[2*SIZE-1:SIZE]} + (mag_b[0] ? {1'b0, mag_a} : '0);
      mul_next  = {mul_sum, acc[SIZE-1:1]};

      // Divide: acc = {quotient, remainder}; dividend bits come from mag_a MSB
      div_shift = {acc[SIZE-1:0], mag_a[SIZE-1]};
      div_ge    = (div_shift >= {1'b0, mag_b});
      div_diff  = div_shift - {1'b0, mag_b};
      div_next  = {acc[2*SIZE-2:SIZE], div_ge,
                   div_ge ? div_diff[SIZE-1:0] : div_shift[SIZE-1:0]};
   end

   // Upper halves of narrow helper results carry no information
   assign unused_hi_halves = ^{a_cond[2*SIZE-1:SIZE], b_cond[2*SIZE-1:SIZE],
                               quo_fix[2*SIZE-1:SIZE], rem_fix[2*SIZE-1:SIZE],
                               a_orig[2*SIZE-1:SIZE], div_diff[SIZE], mul_next[0]};

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= MD_IDLE;
      else     state <= state_nxt;
   end

   // FSM next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         MD_IDLE: begin
            if (start && is_mul)      state_nxt = MD_MUL;
            else if (start && is_div) state_nxt = MD_DIV;
         end
         MD_MUL, MD_DIV: if (last_iter) state_nxt = MD_FIX;
         MD_FIX:  state_nxt = MD_IDLE;
         default: state_nxt = MD_IDLE;
      endcase
   end

   // Datapath: operand capture, iteration, sign fix and HI/LO writeback
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         mag_a  <= '0;
         mag_b  <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         op_div <= 1'b0;
         acc    <= '0;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            MD_IDLE: begin
               if (start) begin
                  if (funcion == FN_MTHI) hi <= op_a;
                  if (funcion == FN_MTLO) lo <= op_a;
                  if (is_mul || is_div) begin
                     mag_a  <= a_cond[SIZE-1:0];
                     mag_b  <= b_cond[SIZE-1:0];
                     sign_a <= neg_a_in;
                     sign_b <= neg_b_in;
                     op_div <= is_div;
                     acc    <= '0;
                     cnt    <= '0;
                  end
               end
            end
            MD_MUL: begin
               acc   <= mul_next;
               mag_b <= mag_b >> 1;
               cnt   <= cnt + CNT_W'(1);
            end
            MD_DIV: begin
               // Rotating the dividend restores it after SIZE steps, so the
               // divide-by-zero path can still return the original op_a.
               acc   <= div_next;
               mag_a <= {mag_a[SIZE-2:0], mag_a[SIZE-1]};
               cnt   <= cnt + CNT_W'(1);
            end
            MD_FIX: begin
               done <= 1'b1;
               if (!op_div) begin
                  {hi, lo} <= prod_fix;
               end else if (mag_b == '0) begin
                  lo <= '1;
                  hi <= a_orig[SIZE-1:0];
               end else begin
                  lo <= quo_fix[SIZE-1:0];
                  hi <= rem_fix[SIZE-1:0];
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [5:0]  funcion;
   logic [31:0] op_a, op_b;
   logic        busy, done;
   logic [31:0] hi, lo, result;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   muldiv_unit #(.SIZE(32), .SIZE_FNC(6), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .start(start), .funcion(funcion),
      .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
      .hi(hi), .lo(lo), .result(result)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Issue one MULT/DIV-class op, count busy cycles, check done and HI/LO
   task automatic run_op(input string tag, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int unsigned cycles;
      @(negedge clk);
      start = 1'b1; funcion = fn; op_a = a; op_b = b;
      @(negedge clk);
      start = 1'b0; funcion = FN_MFLO;
      cycles = 0;
      while (busy && cycles < 100) begin
         cycles++;
         @(negedge clk);
      end
      check({tag, "_busy_cycles"}, cycles, 32'd33);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_hi"}, hi, exp_hi);
      check({tag, "_lo"}, lo, exp_lo);
      @(negedge clk);
      check({tag, "_done_clr"}, 32'(done), 32'd0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned busy_cnt, done_cnt;
      rst = 1'b1; start = 1'b0; funcion = FN_MFLO; op_a = '0; op_b = '0;
      @(negedge clk); @(negedge clk);
      check("rst_hi", hi, 32'h0);
      check("rst_lo", lo, 32'h0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      rst = 1'b0;

      run_op("multu_max", FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
      run_op("mult_neg",  FN_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB);
      run_op("div_neg",   FN_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("divu",      FN_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003);
      run_op("divu_zero", FN_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF);
      run_op("div_zero",  FN_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF);
      run_op("div_ovf",   FN_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

      // MTHI / MTLO then MFHI / MFLO
      @(negedge clk);
      start = 1'b1; funcion = FN_MTHI; op_a = 32'h12345678;
      @(negedge clk);
      check("mthi_busy", 32'(busy), 32'd0);
      funcion = FN_MFHI;
      #1;
      check("mfhi_result", result, 32'h12345678);
      @(negedge clk);
      funcion = FN_MTLO; op_a = 32'hCAFEF00D;
      @(negedge clk);
      check("mtlo_busy", 32'(busy), 32'd0);
      check("mtlo_hi_kept", hi, 32'h12345678);
      funcion = FN_MFLO;
      #1;
      check("mflo_result", result, 32'hCAFEF00D);
      start = 1'b0;

      // MULT with start held for part of the busy window
      @(negedge clk);
      start = 1'b1; funcion = FN_MULT; op_a = 32'd5; op_b = 32'hFFFFFFFE;
      busy_cnt = 0; done_cnt = 0;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         if (i == 19) start = 1'b0;
      end
      check("held_busy_cycles", busy_cnt, 32'd33);
      check("held_done_count", done_cnt, 32'd1);
      check("held_hi", hi, 32'hFFFFFFFF);
      check("held_lo", lo, 32'hFFFFFFF6);

      // Reset in the middle of a divide
      @(negedge clk);
      start = 1'b1; funcion = FN_DIVU; op_a = 32'd100; op_b = 32'd7;
      @(negedge clk);
      start = 1'b0; funcion = FN_MFLO;
      for (int i = 0; i < 10; i++) @(negedge clk);
      check("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_hi", hi, 32'h0);
      check("mid_rst_lo", lo, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      run_op("post_rst_multu", FN_MULTU, 32'd2, 32'd3, 32'h0, 32'h6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
